// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU control codes, datapath mux encodings and the controller state set.
package mips_pkg;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b1001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b1011;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_RST, ST_IF, ST_ID, ST_EX_R, ST_MADDR, ST_MRD,
      ST_MWR, ST_WB_R, ST_WB_M, ST_BR, ST_JMP, ST_FAULT
   } state_t;

endpackage

// File: rtl/alu_func_dec.sv
// Combinational R-type funct decoder: ALU control code plus a legality flag.
// Unsupported functs report legal=0 and fall back to the add code.
module alu_func_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] aluCtr,
   output logic       legal
);

   always_comb begin
      aluCtr = ALU_ADD;
      legal  = 1'b1;
      case (funct)
         FN_ADD:  aluCtr = ALU_ADD;
         FN_SUB:  aluCtr = ALU_SUB;
         FN_AND:  aluCtr = ALU_AND;
         FN_OR:   aluCtr = ALU_OR;
         FN_SLT:  aluCtr = ALU_SLT;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with a shared memory port, variable-latency
// handshake and a sticky timeout fault; all datapath selects/enables come from here.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ins,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        memRd,
   output logic        memWr,
   output logic        iorD,
   output logic        irWr,
   output logic        pcWr,
   output logic        pcWrCond,
   output logic [1:0]  pcSrc,
   output logic        aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [3:0]  aluCtr,
   output logic        extOp,
   output logic        regDst,
   output logic        regWr,
   output logic        memtoReg,
   output logic        instr_done,
   output logic        ill_ins,
   output logic        fault
);

   localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [5:0]    opcode;
   logic [3:0]    r_alu;
   logic          r_legal;
   logic          mem_wait;
   logic          timeout;
   logic          unused_ins;

   assign opcode     = ins[31:26];
   assign unused_ins = ^ins[25:6];

   alu_func_dec u_alu_func_dec (
      .funct  (ins[5:0]),
      .aluCtr (r_alu),
      .legal  (r_legal)
   );

   // Watchdog only arms in the states that hold mem_req high.
   assign mem_wait = (state == ST_IF) || (state == ST_MRD) || (state == ST_MWR);
   assign timeout  = (WAIT_MAX != 0) && mem_wait && !mem_ready && (wait_cnt == WAIT_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RST;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (mem_wait && !mem_ready && (wait_cnt != WAIT_LIM))
            wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      memRd      = 1'b0;
      memWr      = 1'b0;
      iorD       = 1'b0;
      irWr       = 1'b0;
      pcWr       = 1'b0;
      pcWrCond   = 1'b0;
      pcSrc      = PCSRC_ALU;
      aluSrcA    = 1'b0;
      aluSrcB    = SRCB_RT;
      aluCtr     = 4'b0000;
      extOp      = 1'b0;
      regDst     = 1'b0;
      regWr      = 1'b0;
      memtoReg   = 1'b0;
      instr_done = 1'b0;
      ill_ins    = 1'b0;
      fault      = 1'b0;

      case (state)
         ST_RST: state_nxt = ST_IF;

         ST_IF: begin
            mem_req = 1'b1;
            memRd   = 1'b1;
            aluSrcB = SRCB_FOUR;
            aluCtr  = ALU_ADD;
            pcSrc   = PCSRC_ALU;
            irWr    = mem_ready;
            pcWr    = mem_ready;
            if (mem_ready)    state_nxt = ST_ID;
            else if (timeout) state_nxt = ST_FAULT;
         end

         // Branch target is computed speculatively while the opcode decodes.
         ST_ID: begin
            aluSrcB = SRCB_IMM_SH;
            aluCtr  = ALU_ADD;
            extOp   = 1'b1;
            case (opcode)
               OP_R:         state_nxt = r_legal ? ST_EX_R : ST_IF;
               OP_LW, OP_SW: state_nxt = ST_MADDR;
               OP_BEQ:       state_nxt = ST_BR;
               OP_J:         state_nxt = ST_JMP;
               default:      state_nxt = ST_IF;
            endcase
            ill_ins = (opcode == OP_R) ? !r_legal
                    : !((opcode == OP_LW) || (opcode == OP_SW) ||
                        (opcode == OP_BEQ) || (opcode == OP_J));
         end

         ST_EX_R: begin
            aluSrcA   = 1'b1;
            aluSrcB   = SRCB_RT;
            aluCtr    = r_alu;
            state_nxt = ST_WB_R;
         end

         ST_WB_R: begin
            regDst     = 1'b1;
            regWr      = 1'b1;
            instr_done = 1'b1;
            state_nxt  = ST_IF;
         end

         ST_MADDR: begin
            aluSrcA   = 1'b1;
            aluSrcB   = SRCB_IMM;
            aluCtr    = ALU_ADD;
            extOp     = 1'b1;
            state_nxt = (opcode == OP_LW) ? ST_MRD : ST_MWR;
         end

         ST_MRD: begin
            mem_req = 1'b1;
            memRd   = 1'b1;
            iorD    = 1'b1;
            if (mem_ready)    state_nxt = ST_WB_M;
            else if (timeout) state_nxt = ST_FAULT;
         end

         ST_WB_M: begin
            regWr      = 1'b1;
            memtoReg   = 1'b1;
            instr_done = 1'b1;
            state_nxt  = ST_IF;
         end

         ST_MWR: begin
            mem_req    = 1'b1;
            memWr      = 1'b1;
            iorD       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready)    state_nxt = ST_IF;
            else if (timeout) state_nxt = ST_FAULT;
         end

         ST_BR: begin
            aluSrcA    = 1'b1;
            aluSrcB    = SRCB_RT;
            aluCtr     = ALU_SUB;
            pcWrCond   = 1'b1;
            pcSrc      = PCSRC_ALUOUT;
            instr_done = 1'b1;
            state_nxt  = ST_IF;
         end

         ST_JMP: begin
            pcWr       = 1'b1;
            pcSrc      = PCSRC_JUMP;
            instr_done = 1'b1;
            state_nxt  = ST_IF;
         end

         ST_FAULT: fault = 1'b1;

         default: state_nxt = ST_RST;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-accurate scoreboard bench for multicycle_ctrl: each cycle's expected
// output word is queued with its stimulus and compared at the falling edge.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       memRd;
      logic       memWr;
      logic       iorD;
      logic       irWr;
      logic       pcWr;
      logic       pcWrCond;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [3:0] aluCtr;
      logic       extOp;
      logic       regDst;
      logic       regWr;
      logic       memtoReg;
      logic       instr_done;
      logic       ill_ins;
      logic       fault;
   } out_t;

   localparam int T_RST = 0, T_IF = 1, T_ID = 2, T_ID_ILL = 3, T_EXR = 4, T_WBR = 5,
                  T_MADDR = 6, T_MRD = 7, T_MWR = 8, T_WBM = 9, T_BR = 10, T_JMP = 11,
                  T_FAULT = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ins = 32'h0;
   logic        mem_ready = 1'b1;
   logic        mem_req, memRd, memWr, iorD, irWr, pcWr, pcWrCond;
   logic [1:0]  pcSrc, aluSrcB;
   logic        aluSrcA, extOp, regDst, regWr, memtoReg, instr_done, ill_ins, fault;
   logic [3:0]  aluCtr;
   out_t        obs;

   out_t  exp_q[$];
   int    checks = 0;
   int    passes = 0;
   int    cyc_no = 0;
   string cur = "none";

   multicycle_ctrl #(.WAIT_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n), .ins(ins), .mem_ready(mem_ready),
      .mem_req(mem_req), .memRd(memRd), .memWr(memWr), .iorD(iorD),
      .irWr(irWr), .pcWr(pcWr), .pcWrCond(pcWrCond), .pcSrc(pcSrc),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluCtr(aluCtr), .extOp(extOp),
      .regDst(regDst), .regWr(regWr), .memtoReg(memtoReg),
      .instr_done(instr_done), .ill_ins(ill_ins), .fault(fault)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, memRd, memWr, iorD, irWr, pcWr, pcWrCond, pcSrc, aluSrcA,
                 aluSrcB, aluCtr, extOp, regDst, regWr, memtoReg, instr_done,
                 ill_ins, fault};

   function automatic out_t expv(input int st, input logic rdy, input logic [3:0] alu);
      out_t e;
      e = '0;
      case (st)
         T_IF: begin
            e.mem_req = 1'b1; e.memRd = 1'b1; e.aluSrcB = 2'b01; e.aluCtr = 4'b0001;
            e.irWr = rdy; e.pcWr = rdy;
         end
         T_ID, T_ID_ILL: begin
            e.aluSrcB = 2'b11; e.aluCtr = 4'b0001; e.extOp = 1'b1;
            e.ill_ins = (st == T_ID_ILL);
         end
         T_EXR:   begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b00; e.aluCtr = alu; end
         T_WBR:   begin e.regDst = 1'b1; e.regWr = 1'b1; e.instr_done = 1'b1; end
         T_MADDR: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluCtr = 4'b0001; e.extOp = 1'b1; end
         T_MRD:   begin e.mem_req = 1'b1; e.memRd = 1'b1; e.iorD = 1'b1; end
         T_MWR:   begin e.mem_req = 1'b1; e.memWr = 1'b1; e.iorD = 1'b1; e.instr_done = rdy; end
         T_WBM:   begin e.regWr = 1'b1; e.memtoReg = 1'b1; e.instr_done = 1'b1; end
         T_BR: begin
            e.aluSrcA = 1'b1; e.aluCtr = 4'b1001; e.pcWrCond = 1'b1;
            e.pcSrc = 2'b01; e.instr_done = 1'b1;
         end
         T_JMP:   begin e.pcWr = 1'b1; e.pcSrc = 2'b10; e.instr_done = 1'b1; end
         T_FAULT: e.fault = 1'b1;
         default: e = '0;
      endcase
      return e;
   endfunction

   // One clock: queue the expectation with the stimulus, compare mid-cycle.
   task automatic cyc(input int st, input logic rdy, input logic [3:0] alu = 4'b0001);
      out_t got, want;
      mem_ready = rdy;
      exp_q.push_back(expv(st, rdy, alu));
      @(negedge clk);
      got  = obs;
      want = exp_q.pop_front();
      checks++;
      if (got !== want)
         $display("FAIL %s cycle %0d: got %h want %h", cur, cyc_no, got, want);
      else
         passes++;
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cur = "reset";
      rst_n = 1'b0;
      mem_ready = 1'b1;
      ins = 32'h08000010;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== out_t'(0)) $display("FAIL reset_hold: got %h want 0", obs);
      else passes++;
      rst_n = 1'b1;
      cyc(T_RST, 1'b1);
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_JMP, 1'b1);
   endtask

   task automatic test_r_type();
      logic [5:0] fn  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [3:0] alu [5] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b1011};
      cur = "r_type";
      for (int i = 0; i < 5; i++) begin
         ins = {6'b000000, 5'd9, 5'd10, 5'd8, 5'd0, fn[i]};
         cyc(T_IF, 1'b1);
         cyc(T_ID, 1'b1);
         cyc(T_EXR, 1'b1, alu[i]);
         cyc(T_WBR, 1'b1);
      end
   endtask

   task automatic test_lw();
      cur = "lw";
      ins = 32'h8D280004;
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_MADDR, 1'b1);
      cyc(T_MRD, 1'b0);
      cyc(T_MRD, 1'b0);
      cyc(T_MRD, 1'b1);
      cyc(T_WBM, 1'b1);
   endtask

   task automatic test_sw();
      cur = "sw";
      ins = 32'hAD280004;
      cyc(T_IF, 1'b0);
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_MADDR, 1'b1);
      cyc(T_MWR, 1'b0);
      cyc(T_MWR, 1'b1);
   endtask

   task automatic test_branch_jump();
      cur = "beq";
      ins = 32'h11090003;
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_BR, 1'b1);
      cur = "j";
      ins = 32'h08000010;
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_JMP, 1'b1);
   endtask

   task automatic test_illegal();
      cur = "ill_opcode";
      ins = 32'hFC000000;
      cyc(T_IF, 1'b1);
      cyc(T_ID_ILL, 1'b1);
      cur = "ill_funct";
      ins = 32'h012A4027;
      cyc(T_IF, 1'b1);
      cyc(T_ID_ILL, 1'b1);
      cur = "after_ill";
      ins = 32'h08000010;
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_JMP, 1'b1);
   endtask

   task automatic test_watchdog_edge();
      cur = "wd_ready_wins";
      ins = 32'h08000010;
      for (int i = 0; i < 15; i++) cyc(T_IF, 1'b0);
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_JMP, 1'b1);
   endtask

   task automatic test_fault();
      cur = "fault";
      ins = 32'h08000010;
      for (int i = 0; i < 16; i++) cyc(T_IF, 1'b0);
      cyc(T_FAULT, 1'b1);
      cyc(T_FAULT, 1'b0);
      cyc(T_FAULT, 1'b1);
      rst_n = 1'b0;
      #2;
      checks++;
      if (fault !== 1'b0) $display("FAIL fault_async_clear: got %b want 0", fault);
      else passes++;
      checks++;
      if (obs !== out_t'(0)) $display("FAIL fault_reset_outputs: got %h want 0", obs);
      else passes++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cur = "post_fault";
      cyc(T_RST, 1'b1);
      cyc(T_IF, 1'b1);
      cyc(T_ID, 1'b1);
      cyc(T_JMP, 1'b1);
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_lw();
      test_sw();
      test_branch_jump();
      test_illegal();
      test_watchdog_edge();
      test_fault();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS datapath through fetch, decode, execute, memory and writeback.
- Shares one unified instruction/data memory port.
- Supports R-type add/sub/and/or/slt, plus lw, sw, beq and j.
- Adds a variable-latency memory handshake with a timeout watchdog; drives all datapath mux selects and write enables.

Parameters:
- WAIT_MAX, 15: maximum cycles mem_req may stay high without mem_ready before fault. 0 disables the watchdog.
- CW, $clog2(WAIT_MAX+1) (min 1): width of the wait counter (localparam).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ins  in  32  instruction register output; stable from ID until next irWr
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memRd  out  1  read access
- memWr  out  1  write access
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- irWr  out  1  IR load enable
- pcWr  out  1  unconditional PC write
- pcWrCond  out  1  PC write if ALU zero
- pcSrc  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- aluSrcA  out  1  ALU A select: 0=PC, 1=rs
- aluSrcB  out  2  ALU B select: 00=rt, 01=4, 10=ext imm, 11=ext imm<<2
- aluCtr  out  4  ALU op: 0001 add, 1001 sub, 0010 and, 0011 or, 1011 slt
- extOp  out  1  sign-extend immediate
- regDst  out  1  write-register select: 1=rd, 0=rt
- regWr  out  1  register file write
- memtoReg  out  1  register write data: 1=MDR, 0=ALUOut
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction
- ill_ins  out  1  one-cycle pulse in ID for an unsupported opcode/funct
- fault  out  1  sticky memory-timeout flag

Behaviour:
- States: RST, IF, ID, EX_R, MADDR, MRD, MWR, WB_R, WB_M, BR, JMP, FAULT.
- Reset: rst_n low forces state=RST and wait_cnt=0. RST drives all outputs 0. Next cycle goes to IF unconditionally. Reset mid-instruction aborts with no further writes.
- Defaults: every output is 0 unless listed for the current state.
- IF: mem_req=memRd=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtr=0001, pcSrc=00. irWr=pcWr=mem_ready (Mealy). Goes to ID on mem_ready, else stays.
- ID: aluSrcA=0, aluSrcB=11, aluCtr=0001, extOp=1.
  - Next state by opcode: 000000 with legal funct -> EX_R; 100011/101011 -> MADDR; 000100 -> BR; 000010 -> JMP.
  - Anything else: ill_ins=1 -> IF.
- EX_R: aluSrcA=1, aluSrcB=00, aluCtr from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> WB_R.
- WB_R: regDst=1, regWr=1, memtoReg=0, instr_done=1 -> IF.
- MADDR: aluSrcA=1, aluSrcB=10, aluCtr=0001, extOp=1 -> MRD for lw, MWR for sw.
- MRD: mem_req=memRd=1, iorD=1. Goes to WB_M on mem_ready.
- WB_M: regDst=0, regWr=1, memtoReg=1, instr_done=1 -> IF.
- MWR: mem_req=memWr=1, iorD=1. On mem_ready: instr_done=1 -> IF.
- BR: aluSrcA=1, aluSrcB=00, aluCtr=1001, pcWrCond=1, pcSrc=01, instr_done=1 -> IF.
- JMP: pcWr=1, pcSrc=10, instr_done=1 -> IF.
- Latency with zero-wait memory: R=4, lw=5, sw=4, beq=3, j=3 cycles. Each memory wait cycle adds 1.
- Watchdog:
  - wait_cnt clears on every state change. It increments each cycle in IF/MRD/MWR while mem_ready=0, saturating at WAIT_MAX.
  - If wait_cnt==WAIT_MAX, mem_ready=0 and WAIT_MAX!=0: next state is FAULT.
  - mem_ready=1 in that same cycle wins: normal transition.
- FAULT: all outputs 0 except fault=1. Exits only via reset.
- No write enable (regWr, memWr, pcWr, irWr, pcWrCond) is ever asserted outside the states listed above.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants R/LW/SW/BEQ/J
  - funct constants ADD/SUB/AND/OR/SLT
  - aluCtr code constants
  - state enum typedef
  - aluSrcB/pcSrc encodings
- One sub-module, alu_func_dec: combinational funct -> aluCtr plus a legal flag. Used by EX_R and by ID's legality check.

Test Plan:
- Reset, then release with mem_ready=1 held -> cycle 1 RST (all 0); cycle 2 IF with mem_req=1, irWr=pcWr=1.
- add (0x012A4020), mem_ready=1 -> ID, EX_R with aluCtr=0001 aluSrcB=00, then WB_R with regDst=regWr=1, instr_done. Total 4 cycles.
- lw (0x8D280004), mem_ready low for 2 cycles in MRD -> MRD lasts 3 cycles with iorD=1; WB_M has memtoReg=1, regDst=0.
- beq (0x11090003) -> BR with aluCtr=1001, pcWrCond=1, pcSrc=01. j (0x08000010) -> JMP with pcWr=1, pcSrc=10. Each is 3 cycles.
- Opcode 0x3F, and R-type with funct 0x27 -> ill_ins pulse in ID, next state IF, no regWr/memWr asserted.
- WAIT_MAX=15, mem_ready stuck 0 in IF -> fault=1 after 16 IF cycles, outputs 0 thereafter. rst_n low clears fault asynchronously.
